// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU request arbiter slice: FSM state type,
// ALU function codes, default widths and a small one-hot helper.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned FN_W_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHL = 4'd4;
    localparam logic [3:0] ALU_SHR = 4'd5;
    localparam logic [3:0] ALU_DEC = 4'd6;
    localparam logic [3:0] ALU_INC = 4'd7;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (combinational).
//   req     in  2  request lines
//   last    in  1  index of the previous winner
//   gnt     out 2  one-hot grant, 2'b00 when nothing requests
//   gnt_idx out 1  index of the granted port (0 when nothing requests)
module rr_arb2
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    always_comb begin
        gnt_idx = 1'b0;
        gnt     = '0;
        unique case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            // Tie: the port that did not win last time goes first.
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
        if (req != 2'b00) begin
            gnt = onehot2(gnt_idx);
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external ALU between two requesters.
// Requests arrive on per-port valid/ready channels and are picked
// round-robin. The accepted operands are registered toward the ALU, its
// edge-triggered enable is pulsed for one cycle, the result is captured and
// returned on a one-hot response channel that waits for the owner's ready.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-port request handshake
//   req_fn/req_a/req_b/req_cmp  per-port packed request fields
//   rsp_valid/rsp_data/rsp_ready  one-hot response to the owning port
//   busy                    high whenever an operation is in flight
//   alu_enable/alu_fn_sel/alu_a/alu_b/alu_cmpflag  registered ALU drive
//   alu_out                 ALU result, valid after the enable rising edge
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FN_W   = FN_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*FN_W-1:0]   req_fn,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [1:0]          req_cmp,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    input  logic [1:0]          rsp_ready,
    output logic                busy,
    output logic                alu_enable,
    output logic [FN_W-1:0]     alu_fn_sel,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic                alu_cmpflag,
    input  logic [DATA_W-1:0]   alu_out
);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                alu_enable_q, alu_enable_d;
    logic [FN_W-1:0]     fn_q, fn_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                cmp_q, cmp_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    logic [1:0]          gnt;
    logic                gnt_idx;

    rr_arb2 u_rr_arb2 (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        alu_enable_d = 1'b0;
        fn_d         = fn_q;
        a_d          = a_q;
        b_d          = b_q;
        cmp_d        = cmp_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        req_ready    = '0;

        unique case (state_q)
            IDLE: begin
                req_ready = gnt;
                if ((req_valid & gnt) != 2'b00) begin
                    fn_d    = gnt_idx ? req_fn[2*FN_W-1:FN_W]     : req_fn[FN_W-1:0];
                    a_d     = gnt_idx ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
                    b_d     = gnt_idx ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
                    cmp_d   = req_cmp[gnt_idx];
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Enable is registered, so it is requested one state early
                // and is high exactly while the FSM sits in STROBE.
                alu_enable_d = 1'b1;
                state_d      = STROBE;
            end
            STROBE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = onehot2(owner_q);
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            alu_enable_q <= 1'b0;
            fn_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cmp_q        <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            alu_enable_q <= alu_enable_d;
            fn_q         <= fn_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cmp_q        <= cmp_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign alu_enable  = alu_enable_q;
    assign alu_fn_sel  = fn_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_cmpflag = cmp_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [7:0]  req_fn = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [1:0]  req_cmp = '0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_ready = '0;
    logic        busy;
    logic        alu_enable;
    logic [3:0]  alu_fn_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cmpflag;
    logic [7:0]  alu_out = '0;

    int total = 0;
    int bad = 0;

    alu_req_arbiter #(.DATA_W(8), .FN_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fn      (req_fn),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_cmp     (req_cmp),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_ready   (rsp_ready),
        .busy        (busy),
        .alu_enable  (alu_enable),
        .alu_fn_sel  (alu_fn_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cmpflag (alu_cmpflag),
        .alu_out     (alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [3:0] fn, input logic [7:0] a, input logic [7:0] b);
        case (fn)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << b[2:0];
            4'd5: return a >> b[2:0];
            4'd6: return a - 8'd1;
            4'd7: return a + 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    // External ALU: result updates on the rising edge of its enable.
    always @(posedge alu_enable) alu_out <= alu_fn(alu_fn_sel, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // Winner from the round-robin rule; -1 when nobody requests.
    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) return 1 - last;
        return -1;
    endfunction

    // Reference model: an operation is a countdown of cycles since accept.
    bit         m_busy;
    int         m_age;
    int         m_owner;
    int         m_last;
    logic [7:0] m_result, m_rdata, m_a, m_b;
    logic [3:0] m_fn;
    logic       m_cmp;

    int         gq[$];
    logic [8:0] rq[$];
    int         cyc = 0;
    int         acc_cyc = 0, en_cyc = 0, rv_cyc = 0;
    logic [1:0] prev_rv = '0;

    always @(negedge clk) begin
        int g;
        logic [1:0] exp_ready, exp_rv;
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
            m_result = '0; m_rdata = '0; m_a = '0; m_b = '0; m_fn = '0; m_cmp = 0;
            prev_rv = '0;
            chk("rst_busy", busy, 0);
            chk("rst_alu_enable", alu_enable, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_fn", alu_fn_sel, 0);
        end else begin
            g = pick(req_valid, m_last);
            exp_ready = (!m_busy && g >= 0) ? 2'(1 << g) : 2'b00;
            exp_rv    = (m_busy && m_age >= 4) ? 2'(1 << m_owner) : 2'b00;
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, m_busy);
            chk("alu_enable", alu_enable, (m_busy && m_age == 2));
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("rsp_data", rsp_data, m_rdata);
            chk("alu_fn_sel", alu_fn_sel, m_fn);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_cmpflag", alu_cmpflag, m_cmp);

            if ((req_valid & req_ready) != 2'b00) begin
                gq.push_back(req_ready[1] ? 1 : 0);
                acc_cyc = cyc;
            end
            if (alu_enable) en_cyc = cyc;
            if (rsp_valid != 2'b00 && prev_rv == 2'b00) rv_cyc = cyc;
            if ((rsp_valid & rsp_ready) != 2'b00) rq.push_back({rsp_valid[1], rsp_data});
            prev_rv = rsp_valid;

            if (!m_busy) begin
                if (g >= 0) begin
                    m_busy = 1; m_age = 1; m_owner = g; m_last = g;
                    m_fn = req_fn[g*4 +: 4];
                    m_a = req_a[g*8 +: 8];
                    m_b = req_b[g*8 +: 8];
                    m_cmp = req_cmp[g];
                    m_result = alu_fn(m_fn, m_a, m_b);
                end
            end else if (m_age >= 4) begin
                if (rsp_ready[m_owner]) m_busy = 0;
            end else begin
                m_age++;
                if (m_age == 4) m_rdata = m_result;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        gq.delete();
        rq.delete();
    endtask

    task automatic issue(input int p, input logic [3:0] fn, input logic [7:0] a,
                         input logic [7:0] b, input logic cmp);
        int n0 = gq.size();
        int n = 0;
        req_fn[p*4 +: 4] = fn;
        req_a[p*8 +: 8]  = a;
        req_b[p*8 +: 8]  = b;
        req_cmp[p]       = cmp;
        req_valid[p]     = 1'b1;
        while (gq.size() == n0 && n < 40) begin
            next_cycle();
            n++;
        end
        req_valid[p] = 1'b0;
        if (gq.size() == n0) chk("issue_timeout", 0, 1);
    endtask

    task automatic expect_rsp(input string nm, input int owner, input logic [7:0] data);
        int n = 0;
        logic [8:0] r;
        while (rq.size() == 0 && n < 40) begin
            next_cycle();
            n++;
        end
        if (rq.size() == 0) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            r = rq.pop_front();
            chk({nm, "_owner"}, r[8], owner[0]);
            chk({nm, "_data"}, r[7:0], data);
        end
    endtask

    initial begin
        int n;
        do_reset();

        // Port 0 alone: ADD 5+3, latency pinned by hand.
        rsp_ready = 2'b11;
        issue(0, 4'd0, 8'd5, 8'd3, 1'b0);
        expect_rsp("add", 0, 8'd8);
        chk("enable_latency", en_cyc - acc_cyc, 2);
        chk("rsp_latency", rv_cyc - acc_cyc, 4);

        // Both ports held valid after reset: alternate starting with port 0.
        do_reset();
        req_fn = {4'd2, 4'd1};
        req_a  = {8'hF0, 8'd9};
        req_b  = {8'h3C, 8'd4};
        req_valid = 2'b11;
        n = 0;
        while (gq.size() < 4 && n < 60) begin
            next_cycle();
            n++;
        end
        req_valid = 2'b00;
        chk("tie_accept_count", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("tie_g0", gq[0], 0);
            chk("tie_g1", gq[1], 1);
            chk("tie_g2", gq[2], 0);
            chk("tie_g3", gq[3], 1);
        end
        expect_rsp("tie_r0", 0, 8'd5);
        expect_rsp("tie_r1", 1, 8'h30);
        expect_rsp("tie_r2", 0, 8'd5);
        expect_rsp("tie_r3", 1, 8'h30);

        // Backpressure: only non-owner ready, new requests pending.
        rsp_ready = 2'b01;
        issue(1, 4'd3, 8'h55, 8'hA0, 1'b1);
        n = 0;
        while (rsp_valid == 2'b00 && n < 20) begin
            next_cycle();
            n++;
        end
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            chk("hold_rsp_valid", rsp_valid, 2'b10);
            chk("hold_rsp_data", rsp_data, 8'hF5);
            chk("hold_req_ready", req_ready, 2'b00);
            chk("hold_alu_enable", alu_enable, 0);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b10;
        expect_rsp("hold", 1, 8'hF5);
        rsp_ready = 2'b11;
        repeat (2) next_cycle();

        // Asynchronous reset while the strobe is high.
        issue(0, 4'd0, 8'd1, 8'd2, 1'b0);
        n = 0;
        while (!alu_enable && n < 10) begin
            next_cycle();
            n++;
        end
        chk("strobe_seen", alu_enable, 1);
        rst_n = 1'b0;
        #1;
        chk("async_enable", alu_enable, 0);
        chk("async_rsp_valid", rsp_valid, 2'b00);
        chk("async_busy", busy, 0);
        do_reset();
        req_fn = {4'd6, 4'd7};
        req_a  = {8'h10, 8'h7F};
        req_valid = 2'b11;
        n = 0;
        while (gq.size() == 0 && n < 10) begin
            next_cycle();
            n++;
        end
        req_valid = 2'b00;
        chk("post_rst_grant", (gq.size() > 0) ? gq[0] : 9, 0);
        expect_rsp("post_rst", 0, 8'h80);

        // Wrap-around and shift cases.
        issue(0, 4'd6, 8'h00, 8'h00, 1'b0);
        expect_rsp("dec", 0, 8'hFF);
        issue(0, 4'd7, 8'hFF, 8'h00, 1'b0);
        expect_rsp("inc", 0, 8'h00);
        issue(0, 4'd4, 8'h81, 8'h01, 1'b0);
        expect_rsp("shl", 0, 8'h02);

        // Unchecked fn code, then port 1 alone.
        issue(0, 4'd9, 8'h12, 8'h34, 1'b1);
        expect_rsp("fn9", 0, 8'h00);
        gq.delete();
        issue(1, 4'd0, 8'h20, 8'h22, 1'b0);
        chk("p1_alone_grant", (gq.size() > 0) ? gq[0] : 9, 1);
        expect_rsp("p1_alone", 1, 8'h42);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            req_valid = 2'($urandom);
            req_fn    = 8'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_cmp   = 2'($urandom);
            rsp_ready = 2'($urandom);
            next_cycle();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (10) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
